fetch_unit_ras: RTL and testbench
=================================

// Module: fetch_unit_ras
// PURPOSE
//  Parametrised instruction-fetch and program-counter unit for the Simple RISC Machine.
//  Successor to the fixed 9-bit PC / single BL-register path: widths are parametrised,
//  memory has a wait-state handshake with timeout, and a RAS_DEPTH return-address stack replaces BL.
//  Sits between the control FSM (fetch_req, pc_upd, pc_op) and instruction memory; drives the IR value.
// PARAMETERS
//  AW        9   PC / memory address width
//  DW        16  instruction width
//  OFFW      8   signed branch offset width (sximm8)
//  RAS_DEPTH 4   return-address stack entries (>=2)
//  MAX_WAIT  15  max cycles with mem_ready low before fetch abort (>=1)
// PORTS
//  clk        in   1     clock, all state updates on rising edge
//  reset      in   1     synchronous, active-high
//  fetch_req  in   1     start fetch at current pc; accepted only when busy=0
//  pc_upd     in   1     apply pc_op this cycle; accepted only when busy=0
//  pc_op      in   2     00 none, 01 branch rel, 10 return (pop), 11 call (push + branch rel)
//  cond_ok    in   1     branch condition; op 01 changes pc only when 1
//  offset     in   OFFW  signed branch offset
//  mem_ready  in   1     memory has valid read_data this cycle
//  read_data  in   DW    memory read data
//  mem_cmd    out  2     00 MNONE, 01 MREAD
//  mem_addr   out  AW    fetch address (registered)
//  instr      out  DW    last fetched instruction (holds until next successful fetch)
//  instr_valid out 1     one-cycle pulse: instr updated
//  fetch_err  out  1     one-cycle pulse: fetch aborted on timeout
//  pc         out  AW    address of next instruction to fetch
//  busy       out  1     fetch in flight
//  ras_full / ras_empty  out 1 each; ras_ovf / ras_unf  out 1 each, sticky
// BEHAVIOUR
//  Reset: pc=0, mem_cmd=00, mem_addr=0, instr=0, instr_valid=0, fetch_err=0, busy=0,
//   RAS empty (ras_empty=1, ras_full=0), ras_ovf=ras_unf=0, state IDLE, wait count 0.
//  States: IDLE, READ. In IDLE mem_cmd=00, busy=0.
//  IDLE + pc_upd: op 01 & cond_ok: pc <= pc + sext(offset); op 01 & !cond_ok: no change;
//   op 11: push pc, pc <= pc + sext(offset); op 10: pop into pc; op 00: no change.
//   All pc arithmetic modulo 2^AW (wraps both directions).
//  IDLE + fetch_req: -> READ next edge; mem_cmd=01, mem_addr=pc (after any same-cycle pc_upd), busy=1.
//  READ: mem_cmd and mem_addr held stable. mem_ready=1: instr <= read_data, pc <= mem_addr+1,
//   instr_valid=1 in next cycle, -> IDLE. mem_ready=0: wait count +1.
//   wait count reaches MAX_WAIT with mem_ready=0: -> IDLE, fetch_err=1 for one cycle, pc/instr unchanged.
//  Latency: fetch_req at edge k -> mem_cmd=01 from k+1; zero wait states -> instr_valid in cycle k+2.
//   Back-to-back: fetch_req may be reasserted in the instr_valid cycle.
//  fetch_req / pc_upd while busy=1: ignored, no side effects.
//  RAS: push when full discards oldest entry, stores new, sets ras_ovf; pop when empty leaves pc
//   unchanged and sets ras_unf. Sticky flags clear only on reset. Depth = RAS_DEPTH exactly.
//  Reset mid-fetch: next edge returns to reset values; in-flight read discarded, no instr_valid.
// TESTING
//  1 reset, fetch_req, mem_ready=1 first READ cycle, read_data=16'hA5C3 -> mem_addr=0,
//    instr_valid at k+2, instr=A5C3, pc=1.
//  2 pc=5, pc_upd op 01 cond_ok=1 offset=-3 -> pc=2; cond_ok=0 -> pc stays 5; pc=511 seq fetch -> pc=0.
//  3 pc=10, call offset=+20 -> pc=30, then return -> pc=10; 5 calls with depth 4 -> ras_full, ras_ovf=1,
//    4 returns unwind newest-first, 5th return -> pc unchanged, ras_unf=1.
//  4 mem_ready low 3 cycles then high -> mem_cmd=01 / mem_addr stable 4 cycles, single instr_valid;
//    mem_ready never high -> fetch_err pulse after MAX_WAIT=15 cycles, pc unchanged.
//  5 fetch_req and pc_upd op 01 offset=+4 same IDLE cycle at pc=8 -> mem_addr=12;
//    pc_upd during READ -> ignored.
//  6 reset asserted during READ wait -> next cycle mem_cmd=00, pc=0, busy=0, no instr_valid.

Source files
------------

// File: rtl/fetch_unit_ras.sv
// fetch_unit_ras: instruction fetch and PC unit with a return-address stack.
//  The control FSM issues fetch_req_i and pc_upd_i/pc_op_i. Instruction memory
//  is read through a mem_cmd_o/mem_addr_o request with a mem_ready_i wait handshake.
//  If mem_ready_i stays low for MAX_WAIT cycles, the fetch is aborted.
// Ports:
//  clk_i, reset_i        clock, synchronous active-high reset
//  fetch_req_i           start a fetch at the PC (IDLE only)
//  pc_upd_i, pc_op_i     PC op: 00 none, 01 branch rel, 10 return, 11 call
//  cond_ok_i, offset_i   branch condition and signed offset
//  mem_ready_i, read_data_i  memory response
//  mem_cmd_o, mem_addr_o registered memory request (01 = read)
//  instr_o, instr_valid_o last fetched instruction and its update pulse
//  fetch_err_o           timeout-abort pulse
//  pc_o, busy_o          next fetch address, fetch in flight
//  ras_full_o/ras_empty_o, ras_ovf_o/ras_unf_o (sticky)  stack status
module fetch_unit_ras #(
  parameter int AW        = 9,
  parameter int DW        = 16,
  parameter int OFFW      = 8,
  parameter int RAS_DEPTH = 4,
  parameter int MAX_WAIT  = 15
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            fetch_req_i,
  input  logic            pc_upd_i,
  input  logic [1:0]      pc_op_i,
  input  logic            cond_ok_i,
  input  logic [OFFW-1:0] offset_i,
  input  logic            mem_ready_i,
  input  logic [DW-1:0]   read_data_i,
  output logic [1:0]      mem_cmd_o,
  output logic [AW-1:0]   mem_addr_o,
  output logic [DW-1:0]   instr_o,
  output logic            instr_valid_o,
  output logic            fetch_err_o,
  output logic [AW-1:0]   pc_o,
  output logic            busy_o,
  output logic            ras_full_o,
  output logic            ras_empty_o,
  output logic            ras_ovf_o,
  output logic            ras_unf_o
);
  localparam int CW = $clog2(RAS_DEPTH + 1);
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [1:0] MNONE = 2'b00, MREAD = 2'b01;

  typedef enum logic {IDLE, READ} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   pc_q, pc_d, addr_q, addr_d;
  logic [1:0]      cmd_q, cmd_d;
  logic [DW-1:0]   instr_q, instr_d;
  logic            vld_q, vld_d, err_q, err_d, ovf_q, ovf_d, unf_q, unf_d;
  logic [WW-1:0]   wcnt_q, wcnt_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  // ras_q[0] is the top of the stack; the oldest entry falls off the far end
  logic [AW-1:0]   ras_q [RAS_DEPTH];
  logic [AW-1:0]   ras_d [RAS_DEPTH];
  logic [AW-1:0]   off_sx;

  // A size cast of a signed operand sign-extends (or truncates) to AW,
  // so the PC adds below wrap modulo 2^AW in both directions.
  assign off_sx = AW'($signed(offset_i));

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    cmd_d   = cmd_q;
    instr_d = instr_q;
    vld_d   = 1'b0;
    err_d   = 1'b0;
    wcnt_d  = wcnt_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    ras_d   = ras_q;
    case (state_q)
      IDLE: begin
        if (pc_upd_i) begin
          case (pc_op_i)
            2'b01: if (cond_ok_i) pc_d = pc_q + off_sx;
            2'b11: begin
              for (int i = RAS_DEPTH - 1; i > 0; i--) ras_d[i] = ras_q[i-1];
              ras_d[0] = pc_q;
              if (cnt_q == CW'(RAS_DEPTH)) ovf_d = 1'b1;
              else                         cnt_d = cnt_q + CW'(1);
              pc_d = pc_q + off_sx;
            end
            2'b10: begin
              if (cnt_q == '0) unf_d = 1'b1;
              else begin
                pc_d = ras_q[0];
                for (int i = 0; i < RAS_DEPTH - 1; i++) ras_d[i] = ras_q[i+1];
                cnt_d = cnt_q - CW'(1);
              end
            end
            default: ;
          endcase
        end
        // Fetch address takes any same-cycle PC update into account.
        if (fetch_req_i) begin
          state_d = READ;
          cmd_d   = MREAD;
          addr_d  = pc_d;
          wcnt_d  = '0;
        end
      end
      READ: begin
        if (mem_ready_i) begin
          instr_d = read_data_i;
          pc_d    = addr_q + AW'(1);
          vld_d   = 1'b1;
          state_d = IDLE;
          cmd_d   = MNONE;
          wcnt_d  = '0;
        end else if (wcnt_q == WW'(MAX_WAIT - 1)) begin
          // This is the MAX_WAIT-th cycle without data: give up.
          err_d   = 1'b1;
          state_d = IDLE;
          cmd_d   = MNONE;
          wcnt_d  = '0;
        end else begin
          wcnt_d  = wcnt_q + WW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      pc_q    <= '0;
      addr_q  <= '0;
      cmd_q   <= MNONE;
      instr_q <= '0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
      wcnt_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      cmd_q   <= cmd_d;
      instr_q <= instr_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
      wcnt_q  <= wcnt_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= ras_d[i];
    end
  end

  assign mem_cmd_o     = cmd_q;
  assign mem_addr_o    = addr_q;
  assign instr_o       = instr_q;
  assign instr_valid_o = vld_q;
  assign fetch_err_o   = err_q;
  assign pc_o          = pc_q;
  assign busy_o        = (state_q == READ);
  assign ras_full_o    = (cnt_q == CW'(RAS_DEPTH));
  assign ras_empty_o   = (cnt_q == '0);
  assign ras_ovf_o     = ovf_q;
  assign ras_unf_o     = unf_q;
endmodule

// File: tb/tb_fetch_unit_ras.sv
module tb_fetch_unit_ras;
  logic        clk = 0, reset = 1;
  logic        fetch_req = 0, pc_upd = 0, cond_ok = 0, mem_ready = 0;
  logic [1:0]  pc_op = 0;
  logic [7:0]  offset = 0;
  logic [15:0] read_data = 0;
  logic [1:0]  mem_cmd;
  logic [8:0]  mem_addr, pc;
  logic [15:0] instr;
  logic        instr_valid, fetch_err, busy, ras_full, ras_empty, ras_ovf, ras_unf;

  int ntests = 0, nfail = 0;

  typedef struct {bit err; logic [15:0] instr; logic [8:0] pc;} exp_t;
  exp_t sb[$];

  fetch_unit_ras dut (
    .clk_i(clk), .reset_i(reset), .fetch_req_i(fetch_req), .pc_upd_i(pc_upd),
    .pc_op_i(pc_op), .cond_ok_i(cond_ok), .offset_i(offset), .mem_ready_i(mem_ready),
    .read_data_i(read_data), .mem_cmd_o(mem_cmd), .mem_addr_o(mem_addr), .instr_o(instr),
    .instr_valid_o(instr_valid), .fetch_err_o(fetch_err), .pc_o(pc), .busy_o(busy),
    .ras_full_o(ras_full), .ras_empty_o(ras_empty), .ras_ovf_o(ras_ovf), .ras_unf_o(ras_unf));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every instr_valid / fetch_err pulse must match the next expected event.
  always @(negedge clk) begin
    if (instr_valid || fetch_err) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", {30'd0, instr_valid, fetch_err}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("evt_kind", {30'd0, instr_valid, fetch_err}, e.err ? 32'd1 : 32'd2);
        chk("evt_pc", 32'(pc), 32'(e.pc));
        if (!e.err) chk("evt_instr", 32'(instr), 32'(e.instr));
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1; tick(); reset = 0;
  endtask

  task automatic op(input logic [1:0] o, input logic c, input logic [7:0] off);
    pc_upd = 1; pc_op = o; cond_ok = c; offset = off;
    tick();
    pc_upd = 0; pc_op = 0; cond_ok = 0; offset = 0;
  endtask

  // Complete fetch; returns in the instr_valid cycle so the next fetch can chain.
  task automatic fetch(input logic [8:0] addr, input logic [15:0] data, input int waits);
    exp_t e;
    fetch_req = 1; tick(); fetch_req = 0;
    chk("fetch_cmd", 32'(mem_cmd), 32'd1);
    chk("fetch_addr", 32'(mem_addr), 32'(addr));
    chk("fetch_busy", 32'(busy), 32'd1);
    for (int i = 0; i < waits; i++) begin
      tick();
      chk("wait_cmd", 32'(mem_cmd), 32'd1);
      chk("wait_addr", 32'(mem_addr), 32'(addr));
    end
    mem_ready = 1; read_data = data;
    e.err = 0; e.instr = data; e.pc = addr + 9'd1;
    sb.push_back(e);
    tick();
    mem_ready = 0; read_data = 16'h0;
    chk("done_valid", 32'(instr_valid), 32'd1);
  endtask

  initial begin
    exp_t e;
    // Reset values
    reset = 1; tick(); tick(); reset = 0;
    chk("rst_pc", 32'(pc), 0);
    chk("rst_cmd", 32'(mem_cmd), 0);
    chk("rst_addr", 32'(mem_addr), 0);
    chk("rst_instr", 32'(instr), 0);
    chk("rst_flags", {26'd0, instr_valid, fetch_err, busy, ras_full, ras_ovf, ras_unf}, 0);
    chk("rst_empty", 32'(ras_empty), 1);

    // 1: zero-wait fetch, then back-to-back fetch in the instr_valid cycle
    fetch(9'd0, 16'hA5C3, 0);
    fetch(9'd1, 16'h1234, 0);
    tick();
    chk("t1_pc", 32'(pc), 2);
    chk("t1_idle", {30'd0, busy, instr_valid}, 0);

    // 2: conditional branch and PC wrap
    do_reset();
    op(2'b01, 1, 8'd5);  chk("t2_b5", 32'(pc), 5);
    op(2'b01, 1, 8'hFD); chk("t2_bm3", 32'(pc), 2);
    op(2'b01, 1, 8'd3);
    op(2'b01, 0, 8'hFD); chk("t2_nottaken", 32'(pc), 5);
    do_reset();
    op(2'b01, 1, 8'hFF); chk("t2_wrap_neg", 32'(pc), 511);
    fetch(9'd511, 16'hBEEF, 0);
    tick(); chk("t2_wrap_pos", 32'(pc), 0);

    // 3: call/return and stack boundaries
    do_reset();
    op(2'b01, 1, 8'd10);
    op(2'b11, 0, 8'd20); chk("t3_call", 32'(pc), 30);
    op(2'b10, 0, 8'd0);  chk("t3_ret", 32'(pc), 10);
    chk("t3_empty", 32'(ras_empty), 1);
    for (int i = 0; i < 4; i++) op(2'b11, 0, 8'd1);
    chk("t3_full", {30'd0, ras_full, ras_ovf}, 32'd2);
    op(2'b11, 0, 8'd1);
    chk("t3_ovf", {30'd0, ras_full, ras_ovf}, 32'd3);
    chk("t3_pc15", 32'(pc), 15);
    for (int i = 0; i < 4; i++) begin
      op(2'b10, 0, 8'd0);
      chk("t3_unwind", 32'(pc), 32'(14 - i));
    end
    chk("t3_empty2", {30'd0, ras_empty, ras_unf}, 32'd2);
    op(2'b10, 0, 8'd0);
    chk("t3_unf_pc", 32'(pc), 11);
    chk("t3_unf", {30'd0, ras_empty, ras_unf}, 32'd3);

    // 4: wait states, then timeout abort
    do_reset();
    op(2'b01, 1, 8'd7);
    fetch(9'd7, 16'h5A5A, 3);
    tick(); chk("t4_pc", 32'(pc), 8);
    fetch_req = 1; tick(); fetch_req = 0;
    for (int i = 0; i < 14; i++) begin
      chk("t4_still_busy", {30'd0, busy, fetch_err}, 32'd2);
      tick();
    end
    e.err = 1; e.instr = 0; e.pc = 9'd8;
    sb.push_back(e);
    chk("t4_last_wait", 32'(busy), 1);
    tick();
    chk("t4_err", 32'(fetch_err), 1);
    chk("t4_err_idle", {30'd0, busy, mem_cmd[0]}, 0);
    chk("t4_instr_kept", 32'(instr), 32'h5A5A);
    tick(); chk("t4_err_pulse", 32'(fetch_err), 0);

    // 5: fetch with same-cycle branch; PC ops ignored while busy
    do_reset();
    op(2'b01, 1, 8'd8);
    fetch_req = 1; pc_upd = 1; pc_op = 2'b01; cond_ok = 1; offset = 8'd4;
    tick();
    fetch_req = 0; pc_op = 2'b11;
    chk("t5_addr", 32'(mem_addr), 12);
    tick();
    pc_upd = 0; pc_op = 0; cond_ok = 0; offset = 0;
    chk("t5_ignored_pc", 32'(pc), 12);
    chk("t5_ignored_ras", 32'(ras_empty), 1);
    mem_ready = 1; read_data = 16'hC0DE;
    e.err = 0; e.instr = 16'hC0DE; e.pc = 9'd13;
    sb.push_back(e);
    tick(); mem_ready = 0;
    tick(); chk("t5_pc", 32'(pc), 13);

    // 6: reset during a READ wait discards the fetch
    op(2'b01, 1, 8'd3);
    fetch_req = 1; tick(); fetch_req = 0;
    tick(); tick();
    reset = 1; mem_ready = 1; read_data = 16'hDEAD;
    tick();
    reset = 0; mem_ready = 0;
    chk("t6_cmd", 32'(mem_cmd), 0);
    chk("t6_pc", 32'(pc), 0);
    chk("t6_busy", {30'd0, busy, instr_valid}, 0);
    chk("t6_instr", 32'(instr), 0);
    tick(); tick();

    chk("sb_drained", 32'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
